// File: rtl/tlul_host_arb.sv
// Shares one TL-UL device port between NHost hosts; A requests are tagged with the host index and D responses routed back by that tag.
// Round-robin by default; define TLUL_HOST_ARB_FIXED_PRIO_EN for fixed priority (host 0 highest).

package tlul_host_arb_pkg;
   localparam int TL_AW  = 32;
   localparam int TL_DW  = 32;
   localparam int TL_AIW = 8;
   localparam int TL_DBW = 4;
   localparam int TL_SZW = 2;
endpackage

module tlul_host_arb
   import tlul_host_arb_pkg::*;
#(
   parameter int NHost  = 2,
   parameter int MaxOut = 4,
   parameter int HIdW   = $clog2(NHost)
) (
   input  logic                               clk_i,
   input  logic                               rst_i,

   input  logic [NHost-1:0]                   h_a_valid_i,
   output logic [NHost-1:0]                   h_a_ready_o,
   input  logic [NHost-1:0][2:0]              h_a_opcode_i,
   input  logic [NHost-1:0][TL_AW-1:0]        h_a_address_i,
   input  logic [NHost-1:0][TL_DW-1:0]        h_a_data_i,
   input  logic [NHost-1:0][TL_DBW-1:0]       h_a_mask_i,
   input  logic [NHost-1:0][TL_SZW-1:0]       h_a_size_i,
   input  logic [NHost-1:0][TL_AIW-1:0]       h_a_source_i,

   output logic [NHost-1:0]                   h_d_valid_o,
   input  logic [NHost-1:0]                   h_d_ready_i,
   output logic [2:0]                         h_d_opcode_o,
   output logic [TL_DW-1:0]                   h_d_data_o,
   output logic [TL_AIW-1:0]                  h_d_source_o,
   output logic                               h_d_error_o,

   output logic                               dev_a_valid_o,
   input  logic                               dev_a_ready_i,
   output logic [2:0]                         dev_a_opcode_o,
   output logic [TL_AW-1:0]                   dev_a_address_o,
   output logic [TL_DW-1:0]                   dev_a_data_o,
   output logic [TL_DBW-1:0]                  dev_a_mask_o,
   output logic [TL_SZW-1:0]                  dev_a_size_o,
   output logic [TL_AIW-1:0]                  dev_a_source_o,

   input  logic                               dev_d_valid_i,
   output logic                               dev_d_ready_o,
   input  logic [2:0]                         dev_d_opcode_i,
   input  logic [TL_DW-1:0]                   dev_d_data_i,
   input  logic [TL_AIW-1:0]                  dev_d_source_i,
   input  logic                               dev_d_error_i,

   output logic [3:0]                         out_cnt_o,
   output logic                               route_err_o
);

   logic              r_lockValid;
   logic [HIdW-1:0]   r_lockIdx;
   logic [3:0]        r_outCnt;
   logic              r_routeErr;

   logic              w_searchHit;
   logic [HIdW-1:0]   w_searchIdx;
   logic              w_grantReq;
   logic [HIdW-1:0]   w_grantIdx;
   logic              w_full;
   logic              w_devAValid;
   logic              w_aHs;
   logic [HIdW-1:0]   w_dTag;
   logic              w_tagOk;
   logic              w_devDReady;
   logic              w_dHs;
   logic              w_unusedSrcTop;

`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
   // Lowest index wins; scanning downward leaves the lowest requester.
   always_comb begin
      w_searchHit = 1'b0;
      w_searchIdx = '0;
      for (int i = NHost - 1; i >= 0; i--) begin
         if (h_a_valid_i[i]) begin
            w_searchHit = 1'b1;
            w_searchIdx = HIdW'(i);
         end
      end
   end
`else
   logic [HIdW-1:0]   r_rrPtr;
   logic [HIdW-1:0]   w_cand;

   // Scan offsets from the pointer downward so the nearest requester at or after rr_ptr is kept.
   always_comb begin
      w_searchHit = 1'b0;
      w_searchIdx = '0;
      w_cand      = '0;
      for (int i = NHost - 1; i >= 0; i--) begin
         w_cand = HIdW'((int'(r_rrPtr) + i) % NHost);
         if (h_a_valid_i[w_cand]) begin
            w_searchHit = 1'b1;
            w_searchIdx = w_cand;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rrPtr <= '0;
      end else if (w_aHs) begin
         r_rrPtr <= (w_grantIdx == HIdW'(NHost - 1)) ? '0 : w_grantIdx + HIdW'(1);
      end
   end
`endif

   always_comb begin
      if (r_lockValid) begin
         w_grantIdx = r_lockIdx;
         w_grantReq = h_a_valid_i[r_lockIdx];
      end else begin
         w_grantIdx = w_searchIdx;
         w_grantReq = w_searchHit;
      end
   end

   assign w_full      = (r_outCnt == 4'(MaxOut));
   assign w_devAValid = w_grantReq & ~w_full & ~rst_i;
   assign w_aHs       = w_devAValid & dev_a_ready_i;

   always_comb begin
      h_a_ready_o = '0;
      if (w_devAValid) begin
         h_a_ready_o[w_grantIdx] = dev_a_ready_i;
      end
   end

   assign dev_a_valid_o   = w_devAValid;
   assign dev_a_opcode_o  = h_a_opcode_i[w_grantIdx];
   assign dev_a_address_o = h_a_address_i[w_grantIdx];
   assign dev_a_data_o    = h_a_data_i[w_grantIdx];
   assign dev_a_mask_o    = h_a_mask_i[w_grantIdx];
   assign dev_a_size_o    = h_a_size_i[w_grantIdx];
   assign dev_a_source_o  = {w_grantIdx, h_a_source_i[w_grantIdx][TL_AIW-HIdW-1:0]};

   // Host tag bits of the incoming sources are overwritten by the grant index and never forwarded.
   always_comb begin
      w_unusedSrcTop = 1'b0;
      for (int h = 0; h < NHost; h++) begin
         w_unusedSrcTop = w_unusedSrcTop ^ (^h_a_source_i[h][TL_AIW-1 -: HIdW]);
      end
   end

   assign w_dTag  = dev_d_source_i[TL_AIW-1 -: HIdW];
   assign w_tagOk = (int'(w_dTag) < NHost);

   // Responses with a tag beyond the host count are swallowed so the device never stalls.
   always_comb begin
      h_d_valid_o = '0;
      w_devDReady = 1'b1;
      if (w_tagOk) begin
         h_d_valid_o[w_dTag] = dev_d_valid_i & ~rst_i;
         w_devDReady         = h_d_ready_i[w_dTag];
      end
   end

   assign dev_d_ready_o = w_devDReady & ~rst_i;
   assign w_dHs         = dev_d_valid_i & dev_d_ready_o;
   assign h_d_opcode_o  = dev_d_opcode_i;
   assign h_d_data_o    = dev_d_data_i;
   assign h_d_error_o   = dev_d_error_i;
   assign h_d_source_o  = {{HIdW{1'b0}}, dev_d_source_i[TL_AIW-HIdW-1:0]};

   // Lock holds a stalled grant; outstanding count saturates at zero and flags the underflow.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lockValid <= 1'b0;
         r_lockIdx   <= '0;
         r_outCnt    <= '0;
         r_routeErr  <= 1'b0;
      end else begin
         if (w_devAValid && !dev_a_ready_i) begin
            r_lockValid <= 1'b1;
            r_lockIdx   <= w_grantIdx;
         end else if (w_aHs) begin
            r_lockValid <= 1'b0;
         end

         if (w_aHs && !w_dHs) begin
            r_outCnt <= r_outCnt + 4'd1;
         end else if (w_dHs && !w_aHs && (r_outCnt != 4'd0)) begin
            r_outCnt <= r_outCnt - 4'd1;
         end

         if ((dev_d_valid_i && !w_tagOk) || (w_dHs && !w_aHs && (r_outCnt == 4'd0))) begin
            r_routeErr <= 1'b1;
         end
      end
   end

   assign out_cnt_o   = r_outCnt;
   assign route_err_o = r_routeErr;

endmodule

// File: doc/tlul_host_arb.md
# tlul_host_arb

Round-robin arbiter that shares one TL-UL device port between `NHost` TL-UL hosts. It uses the package bus widths `TL_AW`, `TL_DW`, `TL_AIW`, `TL_DBW` and `TL_SZW`. On the A channel, it tags each request's `a_source` with the winning host index. On the D channel, it routes each response back to the owning host by that tag and restores the original source. It sits between the host crossbar ports and a single slave (e.g. the PLIC register file), and caps the number of in-flight transactions.

## Interface
Parameters:
- `NHost`, default 2: number of hosts, legal range 2..4.
- `MaxOut`, default 4: maximum outstanding A transactions across all hosts, legal range 1..15.
- `HIdW`, default `$clog2(NHost)`: width of the host tag. Derived; not for override.

Ports:
- `clk_i`  in  1  clock; the only clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `h_a_valid_i`  in  NHost  per-host A valid.
- `h_a_ready_o`  out  NHost  per-host A ready.
- `h_a_opcode_i`  in  NHost×3  A opcode.
- `h_a_address_i`  in  NHost×TL_AW  A address.
- `h_a_data_i`  in  NHost×TL_DW  A write data.
- `h_a_mask_i`  in  NHost×TL_DBW  A byte mask.
- `h_a_size_i`  in  NHost×TL_SZW  A size.
- `h_a_source_i`  in  NHost×TL_AIW  A source; the top `HIdW` bits must be 0.
- `h_d_valid_o`  out  NHost  per-host D valid.
- `h_d_ready_i`  in  NHost  per-host D ready.
- `h_d_opcode_o`, `h_d_data_o`, `h_d_source_o`, `h_d_error_o`  out  3/TL_DW/TL_AIW/1  D fields, broadcast to all hosts; qualified by that host's `h_d_valid_o`.
- `dev_a_valid_o`, `dev_a_ready_i`, `dev_a_opcode_o`, `dev_a_address_o`, `dev_a_data_o`, `dev_a_mask_o`, `dev_a_size_o`, `dev_a_source_o`  device-side A channel.
- `dev_d_valid_i`, `dev_d_ready_o`, `dev_d_opcode_i`, `dev_d_data_i`, `dev_d_source_i`, `dev_d_error_i`  device-side D channel.
- `out_cnt_o`  out  4  current outstanding count.
- `route_err_o`  out  1  sticky flag: a D response carried an illegal host tag.

## Operation
- **Grant.** Candidates are hosts with `h_a_valid_i` set. The winner is the first candidate at or after `rr_ptr`, wrapping from `NHost-1` to 0.
- **No grant when full.** While `out_cnt == MaxOut`, no host is granted: `dev_a_valid_o = 0` and all `h_a_ready_o = 0`.
- **Lock.** If `dev_a_valid_o = 1` and `dev_a_ready_i = 0`, the current grant is registered in `lock_q` and held until the handshake completes. Another host raising valid cannot steal the slot. This preserves TL-UL valid/payload stability.
- **Request muxing.** `dev_a_*` carries the granted host's fields. `dev_a_source_o` = {grant index, `h_a_source_i[TL_AIW-HIdW-1:0]`}.
- **Granted host ready.** `h_a_ready_o[g] = dev_a_ready_i` for the granted host; all other hosts get 0.
- **Pointer update.** On an A handshake with grant `g`, `rr_ptr` becomes `(g+1) mod NHost`.
- **Response routing.** D tag `t = dev_d_source_i[TL_AIW-1 -: HIdW]`.
  - `t < NHost`: `h_d_valid_o[t] = dev_d_valid_i` and `dev_d_ready_o = h_d_ready_i[t]`.
  - `h_d_source_o` = `dev_d_source_i` with its tag bits zeroed.
- **Illegal tag.** If `t >= NHost` (possible only when `NHost` is not a power of 2):
  - the response is consumed (`dev_d_ready_o = 1`) and no host sees it;
  - `route_err_o` is set and stays set until reset.
- **Outstanding count.**
  - A handshake alone: `out_cnt` +1.
  - D handshake alone, including a dropped response: `out_cnt` −1.
  - Both in the same cycle: unchanged.
  - A D handshake at `out_cnt == 0` does not underflow: the count stays 0 and `route_err_o` is set.

## Timing
- Reset values: `rr_ptr = 0`, `lock_q` cleared, `out_cnt = 0`, `route_err_o = 0`. All valid and ready outputs are 0 in the reset cycle, with the count at 0.
- A path and D path are combinational: 0-cycle latency, no added buffering.
- Grant is recomputed every cycle unless locked. The lock is released in the cycle after the handshake.
- A reset asserted mid-transaction clears all state. In-flight responses after reset are the system's responsibility.
- `out_cnt_o` is registered and reflects handshakes from previous cycles.

## Configuration
- `TLUL_HOST_ARB_FIXED_PRIO_EN` defined: fixed priority, host 0 highest and host `NHost-1` lowest. `rr_ptr` is not implemented. Locking and the outstanding limit behave as above.
- Macro undefined: round-robin as specified above.

## Test plan
- **Reset.** Assert `rst_i` for 2 cycles with all hosts valid -> all `h_a_ready_o = 0`, `dev_a_valid_o = 0`, `out_cnt_o = 0`.
- **Round-robin.** `NHost = 2`, both hosts valid continuously, `dev_a_ready_i = 1` -> grants alternate 0,1,0,1. `dev_a_source_o[7] = 0` and `1` respectively. In fixed-priority mode, host 0 wins every cycle.
- **Lock.** Host 1 granted with `dev_a_ready_i = 0` for 3 cycles while host 0 raises valid -> host 1 keeps the grant with stable payload. Host 0 is granted in the cycle after the handshake.
- **Limit.** `MaxOut = 4`: issue 4 A transactions with no D -> 5th request stalls with `h_a_ready_o = 0`. One D response -> `out_cnt_o` 4→3, then the stalled request proceeds.
- **Routing.** `dev_d_source_i = 8'h85` with `NHost = 2` -> only `h_d_valid_o[1]` asserted, `h_d_source_o = 8'h05`. Simultaneous A and D handshakes leave `out_cnt_o` unchanged.
- **Illegal tag.** `NHost = 3`, `dev_d_source_i = 8'hC0` -> response dropped, `dev_d_ready_o = 1`, `route_err_o = 1` and sticky.
